// File: rtl/seven_seg_scan_decoder.sv
// Receive-side decoder for a 4-digit multiplexed active-low 7-segment scan; rebuilds the 16-bit word.
// Optional build macro SEG_SCAN_CHANGE_ONLY_EN: publish a completed frame only when its word differs from value.
module seven_seg_scan_decoder #(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] value,
  output logic        frame_valid,
  output logic        pattern_err,
  output logic        an_err
);

  localparam logic [CNT_W-1:0] SETTLE = CNT_W'(SETTLE_CYC);

  logic [3:0]       an_m, an_s;
  logic [6:0]       seg_m, seg_s;
  logic [CNT_W-1:0] stable_cnt;
  logic             captured;
  logic [15:0]      digits;
  logic [3:0]       seen;

  logic             same;
  logic [3:0]       sel;
  logic             one_hot;
  logic             illegal;
  logic             fire;
  logic             dec_valid;
  logic [3:0]       dec_code;
  logic             cap_ok;
  logic [3:0]       seen_nx;
  logic [15:0]      digits_nx;
  logic             frame_done;
  logic             publish;

  always_comb begin
    dec_valid = 1'b1;
    dec_code  = 4'h0;
    unique case (seg_s)
      7'h40: dec_code = 4'h0;
      7'h79: dec_code = 4'h1;
      7'h24: dec_code = 4'h2;
      7'h30: dec_code = 4'h3;
      7'h19: dec_code = 4'h4;
      7'h12: dec_code = 4'h5;
      7'h02: dec_code = 4'h6;
      7'h78: dec_code = 4'h7;
      7'h00: dec_code = 4'h8;
      7'h10: dec_code = 4'h9;
      7'h08: dec_code = 4'hA;
      7'h03: dec_code = 4'hB;
      7'h46: dec_code = 4'hC;
      7'h21: dec_code = 4'hD;
      7'h06: dec_code = 4'hE;
      7'h0E: dec_code = 4'hF;
      7'h7F: dec_code = 4'h0;
      default: dec_valid = 1'b0;
    endcase
  end

  // Compare the value about to enter the sync output with the current one, so a
  // change clears the counter on the same edge it lands in an_s/seg_s.
  assign same    = (an_m == an_s) && (seg_m == seg_s);
  assign sel     = ~an_s;
  assign one_hot = (sel != 4'h0) && ((sel & (sel - 4'd1)) == 4'h0);
  assign illegal = (sel != 4'h0) && !one_hot;
  assign fire    = (stable_cnt == SETTLE) && !captured;
  assign cap_ok  = fire && one_hot && dec_valid;
  assign seen_nx = seen | sel;

  always_comb begin
    digits_nx = digits;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) digits_nx[4*i +: 4] = dec_code;
    end
  end

  assign frame_done = cap_ok && (seen_nx == 4'hF);

`ifdef SEG_SCAN_CHANGE_ONLY_EN
  assign publish = frame_done && (digits_nx != value);
`else
  assign publish = frame_done;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_m  <= 4'hF;
      an_s  <= 4'hF;
      seg_m <= 7'h7F;
      seg_s <= 7'h7F;
    end else begin
      an_m  <= an;
      an_s  <= an_m;
      seg_m <= seg;
      seg_s <= seg_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt <= '0;
      captured   <= 1'b0;
    end else if (!same) begin
      stable_cnt <= '0;
      captured   <= 1'b0;
    end else begin
      if (stable_cnt != SETTLE) stable_cnt <= stable_cnt + 1'b1;
      if (fire) captured <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits      <= '0;
      seen        <= '0;
      value       <= '0;
      frame_valid <= 1'b0;
      pattern_err <= 1'b0;
      an_err      <= 1'b0;
    end else begin
      frame_valid <= publish;
      pattern_err <= fire && one_hot && !dec_valid;
      an_err      <= fire && illegal;
      if (cap_ok) begin
        digits <= digits_nx;
        seen   <= frame_done ? 4'h0 : seen_nx;
      end
      if (publish) value <= digits_nx;
    end
  end

endmodule
